// File: rtl/ahb_pkg.sv
// Shared types and defaults for the AHB round-robin arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_LOCKED  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_M        = 4;
  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned WCNT_W           = 4;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational circular first-one finder: scans the mask starting at
// 'start' and wrapping around, returning the first set position.
module ahb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk positions start, start+1, ... mod N and latch the first hit.
  always_comb begin
    int unsigned p;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      p = (int'(start) + k) % N;
      if (!valid && mask[p]) begin
        valid = 1'b1;
        idx   = p[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin within priority class, locked transfers,
// and starvation override driven by per-master wait counters.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_M        = DEF_NUM_M,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NUM_M-1:0]         HBUSREQ,
  input  logic [NUM_M-1:0]         HLOCK,
  input  logic [NUM_M-1:0]         HPRIO,
  input  logic                     HREADY,
  output logic [NUM_M-1:0]         HGRANT,
  output logic [$clog2(NUM_M)-1:0] HMASTER,
  output logic [$clog2(NUM_M)-1:0] HMASTER_D,
  output logic                     HMASTLOCK,
  output logic                     STARVE_EVT
);

  localparam int unsigned IW = $clog2(NUM_M);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_M - 1);
  localparam logic [WCNT_W-1:0] WLIMIT   = WCNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     last_owner, last_d;
  logic [NUM_M-1:0]  grant_d;
  logic [IW-1:0]     master_d;
  logic              starve_d;
  logic [WCNT_W-1:0] wcnt_q [NUM_M];
  logic [WCNT_W-1:0] wcnt_d [NUM_M];

  logic              arb_pt;
  logic [NUM_M-1:0]  starved, prio_req, cand;
  logic [IW-1:0]     start_idx;
  logic              win_valid;
  logic [IW-1:0]     win;

  // Candidate masks: starved requesters, then high-priority, then everyone.
  always_comb begin
    starved   = '0;
    for (int unsigned i = 0; i < NUM_M; i++)
      starved[i] = HBUSREQ[i] && (wcnt_q[i] == WLIMIT);
    prio_req  = HBUSREQ & HPRIO;
    if (|starved)
      cand = starved;
    else if (|prio_req)
      cand = prio_req;
    else
      cand = HBUSREQ;
    start_idx = (last_owner == LAST_IDX) ? '0 : last_owner + 1'b1;
  end

  ahb_rr_pick #(
    .N  (NUM_M),
    .IW (IW)
  ) u_pick (
    .mask  (cand),
    .start (start_idx),
    .valid (win_valid),
    .idx   (win)
  );

  // Next-state and next-grant decode; everything holds outside arbitration points.
  always_comb begin
    arb_pt   = 1'b0;
    state_d  = state_q;
    grant_d  = HGRANT;
    master_d = HMASTER;
    last_d   = last_owner;
    starve_d = 1'b0;
    case (state_q)
      ST_IDLE:    arb_pt = 1'b1;
      ST_GRANTED: arb_pt = HREADY;
      ST_LOCKED:  arb_pt = HREADY && !HLOCK[HMASTER];
      default:    arb_pt = 1'b1;
    endcase
    if (arb_pt) begin
      if (win_valid) begin
        state_d       = HLOCK[win] ? ST_LOCKED : ST_GRANTED;
        grant_d       = '0;
        grant_d[win]  = 1'b1;
        master_d      = win;
        last_d        = win;
        starve_d      = |starved;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end
  end

  // Wait counters advance only at arbitration points, saturating at the limit.
  always_comb begin
    for (int unsigned i = 0; i < NUM_M; i++) begin
      wcnt_d[i] = wcnt_q[i];
      if (arb_pt) begin
        if (!HBUSREQ[i] || (win_valid && (win == IW'(i))))
          wcnt_d[i] = '0;
        else if (wcnt_q[i] != WLIMIT)
          wcnt_d[i] = wcnt_q[i] + 1'b1;
      end
    end
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      HGRANT     <= '0;
      HMASTER    <= '0;
      HMASTER_D  <= '0;
      STARVE_EVT <= 1'b0;
      last_owner <= LAST_IDX;
      for (int unsigned i = 0; i < NUM_M; i++)
        wcnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      HGRANT     <= grant_d;
      HMASTER    <= master_d;
      STARVE_EVT <= starve_d;
      last_owner <= last_d;
      if (HREADY)
        HMASTER_D <= HMASTER;
      for (int unsigned i = 0; i < NUM_M; i++)
        wcnt_q[i] <= wcnt_d[i];
    end
  end

  assign HMASTLOCK = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed-vector bench for ahb_rr_arbiter (NUM_M=4, STARVE_LIMIT=8).
module tb_ahb_rr_arbiter;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] HBUSREQ, HLOCK, HPRIO;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER, HMASTER_D;
  logic       HMASTLOCK, STARVE_EVT;

  int unsigned n_vec;
  int unsigned n_err;

  ahb_rr_arbiter #(
    .NUM_M        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HBUSREQ    (HBUSREQ),
    .HLOCK      (HLOCK),
    .HPRIO      (HPRIO),
    .HREADY     (HREADY),
    .HGRANT     (HGRANT),
    .HMASTER    (HMASTER),
    .HMASTER_D  (HMASTER_D),
    .HMASTLOCK  (HMASTLOCK),
    .STARVE_EVT (STARVE_EVT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  logic [1:0] seq_exp [5];
  logic [1:0] prev_m;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HPRIO   = '0;
    HREADY  = 1'b1;
    do_reset();

    // Reset state
    check_vec("rst_hgrant",  32'(HGRANT),     32'h0);
    check_vec("rst_hmaster", 32'(HMASTER),    32'h0);
    check_vec("rst_hmd",     32'(HMASTER_D),  32'h0);
    check_vec("rst_lock",    32'(HMASTLOCK),  32'h0);
    check_vec("rst_starve",  32'(STARVE_EVT), 32'h0);

    // Round robin over four equal requesters
    seq_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    HBUSREQ = 4'b1111;
    prev_m  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("rr_m%0d", i),  32'(HMASTER),   32'(seq_exp[i]));
      check_vec($sformatf("rr_g%0d", i),  32'(HGRANT),    32'(4'b0001 << seq_exp[i]));
      check_vec($sformatf("rr_d%0d", i),  32'(HMASTER_D), 32'(prev_m));
      prev_m = seq_exp[i];
    end

    // No requesters: grant drops, HMASTER holds
    HBUSREQ = 4'b0000;
    tick();
    check_vec("idle_grant",  32'(HGRANT),  32'h0);
    check_vec("idle_master", 32'(HMASTER), 32'h0);
    // One-cycle grant latency from IDLE
    HBUSREQ = 4'b0010;
    tick();
    check_vec("lat_grant",  32'(HGRANT),  32'h2);
    check_vec("lat_master", 32'(HMASTER), 32'h1);

    // Starvation override
    HBUSREQ = '0;
    do_reset();
    HPRIO   = 4'b1000;
    HBUSREQ = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_vec($sformatf("stv_hi%0d", i), 32'(HMASTER),    32'h3);
      check_vec($sformatf("stv_ev%0d", i), 32'(STARVE_EVT), 32'h0);
    end
    tick();
    check_vec("stv_force_m",  32'(HMASTER),    32'h0);
    check_vec("stv_force_ev", 32'(STARVE_EVT), 32'h1);
    tick();
    check_vec("stv_back_m",   32'(HMASTER),    32'h3);
    check_vec("stv_back_ev",  32'(STARVE_EVT), 32'h0);

    // Locked transfer by master 1 while master 2 waits
    HBUSREQ = '0;
    HPRIO   = '0;
    do_reset();
    HBUSREQ = 4'b0010;
    HLOCK   = 4'b0010;
    tick();
    check_vec("lk_win_m",    32'(HMASTER),   32'h1);
    check_vec("lk_win_lock", 32'(HMASTLOCK), 32'h1);
    HBUSREQ = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("lk_hold_m%0d", i), 32'(HMASTER),   32'h1);
      check_vec($sformatf("lk_hold_l%0d", i), 32'(HMASTLOCK), 32'h1);
    end
    HLOCK   = 4'b0000;
    HBUSREQ = 4'b0100;
    tick();
    check_vec("lk_rel_m",    32'(HMASTER),   32'h2);
    check_vec("lk_rel_g",    32'(HGRANT),    32'h4);
    check_vec("lk_rel_lock", 32'(HMASTLOCK), 32'h0);

    // HREADY low stalls everything; owner 2, HMASTER_D was 1
    HBUSREQ = 4'b1111;
    HREADY  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec($sformatf("wt_g%0d", i), 32'(HGRANT),    32'h4);
      check_vec($sformatf("wt_m%0d", i), 32'(HMASTER),   32'h2);
      check_vec($sformatf("wt_d%0d", i), 32'(HMASTER_D), 32'h1);
    end
    HREADY = 1'b1;
    tick();
    check_vec("wt_go_m", 32'(HMASTER),   32'h3);
    check_vec("wt_go_g", 32'(HGRANT),    32'h8);
    check_vec("wt_go_d", 32'(HMASTER_D), 32'h2);

    // Reset while LOCKED
    HBUSREQ = '0;
    HLOCK   = '0;
    do_reset();
    HBUSREQ = 4'b0100;
    HLOCK   = 4'b0100;
    tick();
    HBUSREQ = 4'b1111;
    tick();
    check_vec("rl_pre_m",    32'(HMASTER),   32'h2);
    check_vec("rl_pre_lock", 32'(HMASTLOCK), 32'h1);
    HRESETn = 1'b0;
    tick();
    check_vec("rl_grant",   32'(HGRANT),     32'h0);
    check_vec("rl_lock",    32'(HMASTLOCK),  32'h0);
    check_vec("rl_master",  32'(HMASTER),    32'h0);
    check_vec("rl_hmd",     32'(HMASTER_D),  32'h0);
    check_vec("rl_starve",  32'(STARVE_EVT), 32'h0);
    HRESETn = 1'b1;
    HLOCK   = 4'b0000;
    tick();
    check_vec("rl_first_m", 32'(HMASTER), 32'h0);
    check_vec("rl_first_g", 32'(HGRANT),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
